// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg
//   Shared NES system-bus definitions: fixed register addresses, the
//   bus_sel encoding used by the top-level address/data mux, and the
//   sprite-DMA state type.
package nes_bus_pkg;

    // cpu write address that starts a sprite DMA
    localparam logic [15:0] TRIGGER_ADDR = 16'h4014;
    // PPU OAMDATA port, destination of every DMA write
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

    // bus_sel encoding: who drives addr/d_out/write on the system bus
    localparam logic BUS_SEL_CPU = 1'b0;
    localparam logic BUS_SEL_DMA = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// oam_dma
//   Sprite-DMA engine. A cpu write of PP to TRIGGER_ADDR halts the cpu and
//   copies LEN bytes from $PP00.. to OAMDATA_ADDR as read/write pairs,
//   optionally inserting one alignment cycle so reads land on even cycles.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   cpu_addr   cpu address output
//   cpu_d_out  cpu write data
//   cpu_write  cpu write strobe
//   d_in       bus read data, valid in the same cycle as the address
//   halt       stall request to the cpu
//   bus_sel    1 = DMA drives addr/d_out/write, 0 = cpu drives them
//   dma_addr   DMA bus address
//   dma_d_out  DMA write data
//   dma_write  DMA write strobe
//   busy       transfer in progress (same as halt)
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = nes_bus_pkg::TRIGGER_ADDR,
    parameter logic [15:0] OAMDATA_ADDR = nes_bus_pkg::OAMDATA_ADDR,
    parameter int unsigned LEN          = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    input  logic [7:0]  d_in,
    output logic        halt,
    output logic        bus_sel,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_d_out,
    output logic        dma_write,
    output logic        busy
);

    localparam logic [8:0] LAST_IDX = 9'(LEN - 1);

    dma_state_t state;
    logic [8:0] idx;
    logic [8:0] idx_inc;
    logic [7:0] page;
    logic       parity;

    always_comb begin
        idx_inc = idx + 9'd1;
    end

    assign busy = halt;

    // All outputs are registered: each transition loads the values the
    // destination state presents. dma_d_out doubles as the read-data latch;
    // it is cleared outside WRITE so the DMA write data only shows when used.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            page      <= '0;
            parity    <= 1'b0;
            halt      <= 1'b0;
            bus_sel   <= BUS_SEL_CPU;
            dma_addr  <= '0;
            dma_d_out <= '0;
            dma_write <= 1'b0;
        end else begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (cpu_write && cpu_addr == TRIGGER_ADDR) begin
                        state    <= WAIT;
                        page     <= cpu_d_out;
                        idx      <= '0;
                        halt     <= 1'b1;
                        bus_sel  <= BUS_SEL_DMA;
                        dma_addr <= cpu_addr;
                    end
                end
                WAIT: begin
                    // parity has toggled once since the trigger edge, so a
                    // low value here means the trigger landed on an odd cycle.
                    if (!parity) begin
                        state <= ALIGN;
                    end else begin
                        state    <= READ;
                        dma_addr <= {page, idx[7:0]};
                    end
                end
                ALIGN: begin
                    state    <= READ;
                    dma_addr <= {page, idx[7:0]};
                end
                READ: begin
                    state     <= WRITE;
                    dma_addr  <= OAMDATA_ADDR;
                    dma_d_out <= d_in;
                    dma_write <= 1'b1;
                end
                WRITE: begin
                    idx       <= idx_inc;
                    dma_write <= 1'b0;
                    dma_d_out <= '0;
                    if (idx == LAST_IDX) begin
                        state    <= IDLE;
                        halt     <= 1'b0;
                        bus_sel  <= BUS_SEL_CPU;
                        dma_addr <= '0;
                    end else begin
                        state    <= READ;
                        dma_addr <= {page, idx_inc[7:0]};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma
//   Self-checking bench for oam_dma: a table of transfers (page, trigger
//   parity, optional retrigger) compared cycle-by-cycle against expected bus
//   activity computed from cycle offsets after the trigger, plus hand-written
//   reset sequences.
module tb_oam_dma;
    import nes_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic [7:0]  d_in;
    logic        halt;
    logic        bus_sel;
    logic [15:0] dma_addr;
    logic [7:0]  dma_d_out;
    logic        dma_write;
    logic        busy;

    oam_dma #(
        .TRIGGER_ADDR(16'h4014),
        .OAMDATA_ADDR(16'h2004),
        .LEN(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_addr(cpu_addr),
        .cpu_d_out(cpu_d_out),
        .cpu_write(cpu_write),
        .d_in(d_in),
        .halt(halt),
        .bus_sel(bus_sel),
        .dma_addr(dma_addr),
        .dma_d_out(dma_d_out),
        .dma_write(dma_write),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // system memory with the top-level bus mux in front of it
    logic [7:0]  mem [0:65535];
    logic [15:0] bus_addr;
    assign bus_addr = bus_sel ? dma_addr : cpu_addr;
    assign d_in     = mem[bus_addr];

    // edges since reset release; its LSB is the parity of the next edge
    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // OAM scoreboard: every DMA write to $2004
    logic [7:0] oam_q [$];
    always @(negedge clk) begin
        if (rst && bus_sel && dma_write && dma_addr == 16'h2004)
            oam_q.push_back(dma_d_out);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {halt, busy, bus_sel, dma_write, dma_addr, data-when-writing}
    function automatic logic [27:0] act_vec();
        return {halt, busy, bus_sel, dma_write, dma_addr, (dma_write ? dma_d_out : 8'h00)};
    endfunction

    // Expected bus state n cycles after the trigger edge: 1+odd cycles of
    // WAIT/ALIGN at $4014, then 256 read/write pairs, then idle.
    function automatic logic [27:0] exp_vec(input logic [7:0] pg, input int odd, input int n);
        int j;
        logic [15:0] src;
        j = n - (2 + odd);
        if (n <= 1 + odd)
            return {3'b111, 1'b0, 16'h4014, 8'h00};
        if (j < 512) begin
            src = {pg, 8'(j / 2)};
            if (j % 2 == 0) return {3'b111, 1'b0, src, 8'h00};
            else            return {3'b111, 1'b1, 16'h2004, mem[src]};
        end
        return '0;
    endfunction

    task automatic cpu_idle();
        cpu_write = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_d_out = 8'h00;
    endtask

    task automatic cpu_noise();
        cpu_write = 1'($urandom);
        cpu_addr  = ($urandom % 4 == 0) ? 16'h4014 : 16'($urandom);
        cpu_d_out = 8'($urandom);
    endtask

    task automatic align(input int odd);
        for (int k = 0; k < 4 && (cyc % 2) != odd; k++) @(negedge clk);
        if ((cyc % 2) != odd) begin
            n_checks++;
            n_fail++;
            $display("FAIL align: parity %0d expected %0d", cyc % 2, odd);
        end
    endtask

    // Drives the trigger at the current negedge and checks every cycle up to
    // and including the first idle cycle; returns at that negedge with the
    // cpu inputs not yet updated so a caller can chain a trigger.
    task automatic do_transfer(input logic [7:0] pg, input int odd, input int retrig_w,
                               input int exp_halt, input int exp_lat, input string tag);
        int halt_cnt;
        int first_read;
        int last_n;
        int retrig_n;
        int bad;
        halt_cnt   = 0;
        first_read = -1;
        last_n     = 514 + odd;
        retrig_n   = (retrig_w > 0) ? (2 * retrig_w + 1 + odd) : -1;
        oam_q.delete();
        cpu_write = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_d_out = pg;
        for (int n = 1; n <= last_n; n++) begin
            @(negedge clk);
            check($sformatf("%s cyc%0d", tag, n), 32'(act_vec()), 32'(exp_vec(pg, odd, n)));
            if (halt) halt_cnt++;
            if (first_read < 0 && bus_sel && !dma_write && dma_addr == {pg, 8'h00})
                first_read = n - 1;
            if (n < last_n) begin
                if (n == retrig_n) begin
                    cpu_write = 1'b1;
                    cpu_addr  = 16'h4014;
                    cpu_d_out = 8'h03;
                end else begin
                    cpu_noise();
                end
            end
        end
        check({tag, " halt length"}, 32'(halt_cnt), 32'(exp_halt));
        check({tag, " first read latency"}, 32'(first_read), 32'(exp_lat));
        check({tag, " oam write count"}, 32'(oam_q.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (i >= oam_q.size() || oam_q[i] !== mem[{pg, 8'(i)}]) bad++;
        check({tag, " oam bytes wrong"}, 32'(bad), 32'd0);
    endtask

    typedef struct {
        logic [7:0] page;
        int         odd;
        bit         chain;
        int         retrig_w;
        int         exp_halt;
        int         exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rnd_odd;
        bit found;

        rst = 1'b0;
        cpu_idle();
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        // reset held for 3 cycles with cpu activity: everything stays 0
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reset outs %0d", k), 32'(act_vec()), 32'd0);
            cpu_noise();
        end
        rst = 1'b1;
        cpu_idle();
        @(negedge clk);
        check("idle after reset", 32'(act_vec()), 32'd0);

        vecs[0] = '{8'h02, 0, 1'b0, 0,   513, 1};
        vecs[1] = '{8'h02, 1, 1'b0, 100, 514, 2};
        // chained straight after an odd transfer: lands on an even edge
        vecs[2] = '{8'h03, 0, 1'b1, 0,   513, 1};
        vecs[3] = '{8'hFF, 1, 1'b0, 0,   514, 2};
        for (int v = 4; v < 6; v++) begin
            rnd_odd = int'($urandom % 2);
            vecs[v] = '{8'($urandom), rnd_odd, 1'b0, 0, 513 + rnd_odd, 1 + rnd_odd};
        end

        for (int v = 0; v < 6; v++) begin
            if (!vecs[v].chain) begin
                cpu_idle();
                align(vecs[v].odd);
            end
            do_transfer(vecs[v].page, vecs[v].odd, vecs[v].retrig_w,
                        vecs[v].exp_halt, vecs[v].exp_lat, $sformatf("vec%0d", v));
        end

        // reset mid-transfer at idx $40
        cpu_idle();
        align(0);
        oam_q.delete();
        cpu_write = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_d_out = 8'h02;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            cpu_idle();
            if (bus_sel && !dma_write && dma_addr == 16'h0240) found = 1'b1;
        end
        check("reach idx 40", 32'(found), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async reset outs", 32'(act_vec()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("held reset outs %0d", k), 32'(act_vec()), 32'd0);
        end
        check("aborted oam count", 32'(oam_q.size()), 32'd64);
        rst = 1'b1;
        @(negedge clk);
        check("idle after abort", 32'(act_vec()), 32'd0);
        align(0);
        do_transfer(8'h05, 0, 0, 513, 1, "after abort");
        cpu_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
